// File: rtl/mc_alu_pkg.sv
// alu_pkg: shared op codes, default width and FSM state encoding for mc_alu
package alu_pkg;
  localparam int WIDTH = 32;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_NOR = 4'h6;
  localparam logic [3:0] OP_SLL = 4'h7;
  localparam logic [3:0] OP_SRL = 4'h8;
  localparam logic [3:0] OP_SLT = 4'h9;
  localparam logic [3:0] OP_XOR = 4'hA;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/mc_alu_if.sv
// mc_alu_if: op/result handshake bundle for mc_alu
//   master drives in_valid/op/a/b/shamt/out_ready; slave drives in_ready/out_valid/result/zero/div_by_zero
interface mc_alu_if #(parameter int WIDTH = alu_pkg::WIDTH);
  logic                     in_valid;
  logic                     in_ready;
  logic [3:0]               op;
  logic [WIDTH-1:0]         a;
  logic [WIDTH-1:0]         b;
  logic [$clog2(WIDTH)-1:0] shamt;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         result;
  logic                     zero;
  logic                     div_by_zero;
  modport master (output in_valid, op, a, b, shamt, out_ready,
                  input  in_ready, out_valid, result, zero, div_by_zero);
  modport slave  (input  in_valid, op, a, b, shamt, out_ready,
                  output in_ready, out_valid, result, zero, div_by_zero);
endinterface

// File: rtl/mc_alu_muldiv.sv
// mc_alu_muldiv: iterative shift-add multiplier / signed restoring divider, one bit per iter_en
//   i_start loads operands, i_iter_en advances one step, o_final_result is the value after the current step
module mc_alu_muldiv #(parameter int WIDTH = alu_pkg::WIDTH) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_iter_en,
  output logic [WIDTH-1:0] o_final_result
);
  logic             r_div, r_neg;
  logic [WIDTH-1:0] r_x, r_y, r_acc;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_x_n, w_acc_n;
  logic [WIDTH:0]   w_sh, w_diff;
  // mul: r_x multiplicand, r_y multiplier, r_acc product
  // div: r_x dividend shifting out / quotient shifting in, r_y divisor magnitude, r_acc remainder
  assign w_abs_a = i_a[WIDTH-1] ? -i_a : i_a;
  assign w_abs_b = i_b[WIDTH-1] ? -i_b : i_b;
  assign w_sh    = {r_acc, r_x[WIDTH-1]};
  assign w_diff  = w_sh - {1'b0, r_y};
  assign w_x_n   = r_div ? {r_x[WIDTH-2:0], ~w_diff[WIDTH]} : r_x << 1;
  assign w_acc_n = r_div ? (w_diff[WIDTH] ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0])
                         : r_acc + (r_y[0] ? r_x : '0);
  assign o_final_result = r_div ? (r_neg ? -w_x_n : w_x_n) : w_acc_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= 1'b0;
      r_neg <= 1'b0;
      r_x   <= '0;
      r_y   <= '0;
      r_acc <= '0;
    end else if (i_start) begin
      r_div <= i_is_div;
      r_neg <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
      r_x   <= i_is_div ? w_abs_a : i_a;
      r_y   <= i_is_div ? w_abs_b : i_b;
      r_acc <= '0;
    end else if (i_iter_en) begin
      r_x   <= w_x_n;
      r_y   <= r_div ? r_y : r_y >> 1;
      r_acc <= w_acc_n;
    end
  end
endmodule

// File: rtl/mc_alu.sv
// mc_alu: multi-cycle execute ALU with valid/ready handshake; single-cycle ops plus 32-step MUL/DIV
//   clk, rst_n (async active-low), bus: mc_alu_if.slave carrying op/operands in and result/flags out
module mc_alu
  import alu_pkg::*;
#(parameter int WIDTH = alu_pkg::WIDTH) (
  input  logic      clk,
  input  logic      rst_n,
  mc_alu_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);
  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result, w_alu, w_md;
  logic             r_dbz, r_bz;
  logic             w_acc, w_long, w_last;
  assign w_acc  = bus.in_valid && r_state == IDLE;
  assign w_long = bus.op == OP_MUL || bus.op == OP_DIV;
  assign w_last = r_cnt == CW'(WIDTH-1);
  assign bus.in_ready    = r_state == IDLE;
  assign bus.out_valid   = r_state == DONE;
  assign bus.result      = r_result;
  assign bus.zero        = r_result == '0;
  assign bus.div_by_zero = r_dbz;
  always_comb begin
    w_alu = '0;
    case (bus.op)
      OP_ADD:  w_alu = bus.a + bus.b;
      OP_SUB:  w_alu = bus.a - bus.b;
      OP_AND:  w_alu = bus.a & bus.b;
      OP_OR:   w_alu = bus.a | bus.b;
      OP_NOR:  w_alu = ~(bus.a | bus.b);
      OP_XOR:  w_alu = bus.a ^ bus.b;
      OP_SLL:  w_alu = bus.b << bus.shamt;
      OP_SRL:  w_alu = bus.b >> bus.shamt;
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      default: w_alu = '0;
    endcase
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_acc ? (w_long ? BUSY : DONE) : IDLE;
      BUSY:    w_next = w_last ? DONE : BUSY;
      DONE:    w_next = bus.out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_result <= '0;
      r_dbz    <= 1'b0;
      r_bz     <= 1'b0;
    end else if (w_acc) begin
      r_cnt    <= '0;
      r_dbz    <= 1'b0;
      r_bz     <= bus.op == OP_DIV && bus.b == '0;
      r_result <= w_long ? r_result : w_alu;
    end else if (r_state == BUSY) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        // divide-by-zero reports all ones regardless of operand signs
        r_result <= r_bz ? '1 : w_md;
        r_dbz    <= r_bz;
      end
    end
  end
  mc_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (w_acc && w_long),
    .i_is_div       (bus.op == OP_DIV),
    .i_a            (bus.a),
    .i_b            (bus.b),
    .i_iter_en      (r_state == BUSY),
    .o_final_result (w_md)
  );
endmodule

// File: tb/tb_mc_alu.sv
// tb_mc_alu: directed-vector self-checking bench for mc_alu
module tb_mc_alu;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   lat;
  logic [31:0] res;
  logic zf, dbz, busy_rdy;
  mc_alu_if #(.WIDTH(32)) bus ();
  mc_alu #(.WIDTH(32)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // presents one op, scrambles inputs after accept, waits for out_valid (bounded)
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.shamt = sh;
    lat = 0;
    busy_rdy = 1'b0;
    do begin
      @(posedge clk) #1;
      lat++;
      bus.op = OP_ADD;
      bus.a = 32'hDEAD_BEEF;
      bus.b = 32'h1234_5678;
      bus.shamt = 5'd3;
      if (!bus.out_valid) busy_rdy |= bus.in_ready;
    end while (!bus.out_valid && lat < 100);
    bus.in_valid = 1'b0;
    res = bus.result;
    zf = bus.zero;
    dbz = bus.div_by_zero;
    if (bus.out_ready) @(posedge clk) #1;
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    bus.shamt = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_zero", bus.zero, 1);
    rst_n = 1'b1;
    @(posedge clk) #1;
    run_op(OP_ADD, 32'd5, 32'd7, 0);
    check("add_lat", lat, 1);
    check("add_res", res, 12);
    check("add_zero", zf, 0);
    check("add_idle", bus.in_ready, 1);
    run_op(OP_SUB, 32'd7, 32'd7, 0);
    check("sub_res", res, 0);
    check("sub_zero", zf, 1);
    run_op(OP_MUL, 32'h0001_0000, 32'h0001_0003, 0);
    check("mul_lat", lat, 33);
    check("mul_res", res, 32'h0003_0000);
    check("mul_busy_ready", busy_rdy, 0);
    run_op(OP_MUL, 32'hFFFF_FFFD, 32'd6, 0);
    check("mul_neg", res, 32'hFFFF_FFEE);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_lat", lat, 33);
    check("div_neg7_2", res, 32'hFFFF_FFFD);
    check("div_neg7_2_dbz", dbz, 0);
    run_op(OP_DIV, 32'd100, 32'd7, 0);
    check("div_100_7", res, 32'd14);
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 0);
    check("div_7_neg2", res, 32'hFFFF_FFFD);
    run_op(OP_DIV, 32'd100, 32'd0, 0);
    check("div0_lat", lat, 33);
    check("div0_res", res, 32'hFFFF_FFFF);
    check("div0_flag", dbz, 1);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_min_m1", res, 32'h8000_0000);
    check("div_min_m1_dbz", dbz, 0);
    run_op(OP_DIV, 32'd5, 32'd0, 0);
    run_op(OP_ADD, 32'd1, 32'd1, 0);
    check("dbz_clear", dbz, 0);
    run_op(OP_AND, 32'hF0F0_1234, 32'h0FF0_00FF, 0);
    check("and", res, 32'h00F0_0034);
    run_op(OP_OR, 32'hF0F0_1234, 32'h0FF0_00FF, 0);
    check("or", res, 32'hFFF0_12FF);
    run_op(OP_XOR, 32'hF0F0_1234, 32'h0FF0_00FF, 0);
    check("xor", res, 32'hFF00_12CB);
    run_op(OP_NOR, 32'hF0F0_1234, 32'h0FF0_00FF, 0);
    check("nor", res, 32'h000F_ED00);
    run_op(OP_SLT, 32'hFFFF_FFFF, 32'd1, 0);
    check("slt_m1_1", res, 1);
    run_op(OP_SLT, 32'd1, 32'hFFFF_FFFF, 0);
    check("slt_1_m1", res, 0);
    run_op(OP_SLL, 32'h0, 32'd1, 5'd31);
    check("sll31", res, 32'h8000_0000);
    run_op(OP_SLL, 32'h0, 32'hA5A5_0001, 5'd0);
    check("sll0", res, 32'hA5A5_0001);
    run_op(OP_SRL, 32'h0, 32'h8000_0000, 5'd31);
    check("srl31", res, 1);
    run_op(OP_ADD, 32'd3, 32'd4, 0);
    run_op(4'hF, 32'd3, 32'd4, 0);
    check("undef_op", res, 0);
    check("undef_lat", lat, 1);
    bus.out_ready = 1'b0;
    run_op(OP_SUB, 32'd10, 32'd3, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk) #1;
      check("bp_valid", bus.out_valid, 1);
      check("bp_result", bus.result, 7);
      check("bp_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk) #1;
    check("bp_release_valid", bus.out_valid, 0);
    check("bp_release_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.op = OP_MUL;
    bus.a = 32'd9;
    bus.b = 32'd9;
    @(posedge clk) #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    check("mid_busy_ready", bus.in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("abort_ready", bus.in_ready, 1);
    check("abort_valid", bus.out_valid, 0);
    check("abort_result", bus.result, 0);
    @(posedge clk) #1;
    rst_n = 1'b1;
    busy_rdy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk) #1;
      busy_rdy |= bus.out_valid;
    end
    check("abort_no_valid", busy_rdy, 0);
    run_op(OP_ADD, 32'hFFFF_FFFF, 32'd2, 0);
    check("post_abort_add", res, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mc_alu.md
Name: mc_alu

Overview:
- Execute-stage ALU that consumes the 4-bit operation code produced by the ALU control decoder. Operates on two 32-bit operands.
- Single-cycle ops (add/sub/logic/shift/compare) return a registered result after one cycle.
- MUL and DIV run iteratively over 32 cycles.
- valid/ready handshake on both sides, so the pipeline stalls on long ops.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  op/operands valid.
- in_ready  output  1  block can accept a new op.
- op  input  4  ALU op code: 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 AND, 0101 OR, 0110 NOR, 0111 SLL, 1000 SRL, 1001 SLT, 1010 XOR.
- a  input  WIDTH  operand A (rs).
- b  input  WIDTH  operand B (rt / immediate).
- shamt  input  5  shift amount for SLL/SRL.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- div_by_zero  output  1  last DIV had b == 0; valid with out_valid.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (rst_n). On reset:
  - state=IDLE, result=0, out_valid=0, div_by_zero=0, iteration counter=0.
  - zero=1, since it is combinational from result.
- State machine: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
  - Accept = in_valid && in_ready. op/a/b/shamt are captured on accept; later input changes are ignored.
- IDLE, accept of a single-cycle op: result computed and registered, next state DONE. out_valid rises on the cycle after accept (latency 1).
- IDLE, accept of MUL/DIV: operands loaded into the muldiv unit, counter=0, next state BUSY.
- BUSY: one iteration per cycle. On the 32nd iteration (counter==WIDTH-1) the final result is registered and the next state is DONE. out_valid rises exactly WIDTH+1 cycles after the accept edge (33).
- DONE: result held stable while out_ready=0. When out_ready=1, next state is IDLE.
  - No accept in DONE.
  - Peak throughput is one op per 2 cycles.
- Arithmetic rules:
  - ADD/SUB: modulo 2^WIDTH; no overflow trap.
  - AND/OR/XOR/NOR: bitwise a op b.
  - SLL: b << shamt. SRL: logical b >> shamt. shamt=0 yields b.
  - SLT: 1 if $signed(a) < $signed(b), else 0.
  - MUL: shift-add; result is the low WIDTH bits of a*b (identical for signed and unsigned).
  - DIV: signed restoring division on magnitudes, quotient truncated toward zero. Quotient negated if sign(a) != sign(b). Remainder discarded.
  - DIV with b==0: still takes 33 cycles; result=32'hFFFFFFFF, div_by_zero=1.
  - DIV of 0x80000000 by 0xFFFFFFFF: result=0x80000000, no flag.
  - div_by_zero is cleared on every accept.
- Undefined op codes (1011–1111): single-cycle, result=0.
- Reset mid-BUSY or mid-DONE: aborts the op immediately; no out_valid is produced.

Decomposition:
- Package alu_pkg holds:
  - localparams for the 11 op codes (OP_ADD…OP_XOR);
  - WIDTH default;
  - state enum encoding (IDLE/BUSY/DONE).
- Sub-module mc_alu_muldiv handles the iterative datapath:
  - registers: multiplicand/multiplier/product accumulator, or dividend/divisor/remainder, plus sign-correction logic;
  - interface: start, is_div, a, b, iter_en, final_result.
- Top-level mc_alu holds the FSM, the counter, the single-cycle datapath and the handshake.

Test Plan:
- Reset then idle: in_ready=1, out_valid=0, result=0, zero=1.
- ADD a=5, b=7, out_ready=1: out_valid on next cycle, result=12, zero=0. Then SUB a=7, b=7: result=0, zero=1.
- MUL a=0x0001_0000, b=0x0001_0003: out_valid exactly 33 cycles after accept, result=0x0003_0000. in_ready=0 throughout BUSY; input changes during BUSY ignored.
- DIV signed cases:
  - a=-7 (0xFFFFFFF9), b=2: result=0xFFFFFFFD (-3).
  - a=100, b=0: result=0xFFFFFFFF, div_by_zero=1.
- SLT a=-1, b=1 gives result=1. SLL b=1, shamt=31 gives 0x80000000. SRL b=0x80000000, shamt=31 gives 1. op=1111 gives 0.
- Backpressure: out_ready=0 for 5 cycles in DONE leaves result and out_valid stable. Asserting rst_n=0 mid-BUSY (cycle 10 of MUL) gives IDLE, out_valid=0 and no stale result.
